// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the TMR ALU fault manager.
// The state encoding is visible on state_o, so values are fixed explicitly.
package cv32e40p_pkg;

    localparam int FAULT_RETRY_MAX = 3;

    typedef enum logic [1:0] {
        FM_IDLE   = 2'd0,
        FM_RETRY  = 2'd1,
        FM_PERM   = 2'd2,
        FM_UNUSED = 2'd3
    } fault_mgr_state_e;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter used for the lifetime count of qualified faults.
// A clear in the same cycle as an increment wins.
module cv32e40p_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_fault_mgr.sv
// Fault manager for the triplicated ALU: replays transient voter mismatches
// and declares a permanent fault once too many happen back to back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FM_IDLE  | no outstanding fault
// FM_RETRY | replay requested, waiting for the re-executed result
// FM_PERM  | replay budget exhausted, held until clear_i
// FM_UNUSED| illegal, falls back to FM_IDLE
module cv32e40p_tmr_fault_mgr
    import cv32e40p_pkg::*;
#(
    parameter int RETRY_MAX = FAULT_RETRY_MAX,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             res_fault_i,
    input  logic             comp_fault_i,
    input  logic             ready_fault_i,
    input  logic             clear_i,
    input  logic             cnt_clr_i,
    output logic             retry_req_o,
    output logic             perm_fault_o,
    output logic             irq_o,
    output logic [2:0]       fault_src_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic [1:0]       state_o
);

    localparam logic [3:0] RETRY_LIMIT = 4'(RETRY_MAX);

    fault_mgr_state_e state;
    logic [3:0]       consec_cnt;
    logic [2:0]       fault_vec;
    logic             qual_fault;

    assign fault_vec  = {ready_fault_i, comp_fault_i, res_fault_i};
    assign qual_fault = valid_i && (fault_vec != 3'b000);
    assign state_o    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FM_IDLE;
            consec_cnt   <= '0;
            fault_src_o  <= '0;
            retry_req_o  <= 1'b0;
            irq_o        <= 1'b0;
            perm_fault_o <= 1'b0;
        end else begin
            retry_req_o <= 1'b0;
            irq_o       <= 1'b0;
            // An acknowledge discards any fault presented in the same cycle.
            if (clear_i) begin
                state        <= FM_IDLE;
                consec_cnt   <= '0;
                fault_src_o  <= '0;
                perm_fault_o <= 1'b0;
            end else begin
                if (qual_fault) begin
                    fault_src_o <= fault_src_o | fault_vec;
                end
                case (state)
                    FM_IDLE: begin
                        if (qual_fault) begin
                            state       <= FM_RETRY;
                            consec_cnt  <= 4'd1;
                            retry_req_o <= 1'b1;
                        end
                    end
                    FM_RETRY: begin
                        if (qual_fault) begin
                            if (consec_cnt < RETRY_LIMIT) begin
                                consec_cnt  <= consec_cnt + 4'd1;
                                retry_req_o <= 1'b1;
                            end else begin
                                state        <= FM_PERM;
                                perm_fault_o <= 1'b1;
                                irq_o        <= 1'b1;
                            end
                        end else if (valid_i) begin
                            state      <= FM_IDLE;
                            consec_cnt <= '0;
                        end
                    end
                    FM_PERM: begin
                        perm_fault_o <= 1'b1;
                    end
                    default: begin
                        state        <= FM_IDLE;
                        consec_cnt   <= '0;
                        perm_fault_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    cv32e40p_sat_counter #(
        .W(CNT_W)
    ) u_fault_cnt (
        .clk (clk),
        .rst (rst),
        .inc (qual_fault && !clear_i),
        .clr (cnt_clr_i),
        .cnt (fault_cnt_o)
    );

endmodule

// File: tb/tb_cv32e40p_tmr_fault_mgr.sv
// Bench for the TMR fault manager: directed scenarios then random traffic,
// both scored against a behavioural model; a narrow-counter instance shares the stimulus.
module tb_cv32e40p_tmr_fault_mgr;

    localparam int RM = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_i = 1'b0, res_fault_i = 1'b0, comp_fault_i = 1'b0, ready_fault_i = 1'b0;
    logic clear_i = 1'b0, cnt_clr_i = 1'b0;

    logic       retry_a, perm_a, irq_a, retry_b, perm_b, irq_b;
    logic [2:0] src_a, src_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] st_a, st_b;

    always #5 clk = ~clk;

    cv32e40p_tmr_fault_mgr #(.RETRY_MAX(RM), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .res_fault_i(res_fault_i),
        .comp_fault_i(comp_fault_i), .ready_fault_i(ready_fault_i),
        .clear_i(clear_i), .cnt_clr_i(cnt_clr_i), .retry_req_o(retry_a),
        .perm_fault_o(perm_a), .irq_o(irq_a), .fault_src_o(src_a),
        .fault_cnt_o(cnt_a), .state_o(st_a)
    );

    cv32e40p_tmr_fault_mgr #(.RETRY_MAX(RM), .CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .valid_i(valid_i), .res_fault_i(res_fault_i),
        .comp_fault_i(comp_fault_i), .ready_fault_i(ready_fault_i),
        .clear_i(clear_i), .cnt_clr_i(cnt_clr_i), .retry_req_o(retry_b),
        .perm_fault_o(perm_b), .irq_o(irq_b), .fault_src_o(src_b),
        .fault_cnt_o(cnt_b), .state_o(st_b)
    );

    // Behavioural model: mode 0 = no fault pending, 1 = replaying, 2 = permanent.
    int   m_mode, m_run, m_cnt_a, m_cnt_b;
    logic [2:0] m_src;
    logic m_retry, m_irq;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",      32'(st_a),    32'(m_mode));
        chk("retry_req",  32'(retry_a), 32'(m_retry));
        chk("perm_fault", 32'(perm_a),  32'(m_mode == 2));
        chk("irq",        32'(irq_a),   32'(m_irq));
        chk("fault_src",  32'(src_a),   32'(m_src));
        chk("fault_cnt",  32'(cnt_a),   32'(m_cnt_a));
        chk("n_state",    32'(st_b),    32'(m_mode));
        chk("n_retry",    32'(retry_b), 32'(m_retry));
        chk("n_irq",      32'(irq_b),   32'(m_irq));
        chk("n_fault_cnt",32'(cnt_b),   32'(m_cnt_b));
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_src = 3'b000;
        m_retry = 1'b0; m_irq = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    task automatic model_step(input logic v, input logic r, input logic c,
                              input logic y, input logic cl, input logic cc);
        bit q;
        q = v && (r || c || y);
        m_retry = 1'b0;
        m_irq   = 1'b0;
        if (cc) begin
            m_cnt_a = 0; m_cnt_b = 0;
        end else if (q && !cl) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
        end
        if (cl) begin
            m_mode = 0; m_run = 0; m_src = 3'b000;
        end else if (q) begin
            m_src = m_src | {y, c, r};
            if (m_mode == 0) begin
                m_mode = 1; m_run = 1; m_retry = 1'b1;
            end else if (m_mode == 1) begin
                if (m_run < RM) begin
                    m_run++; m_retry = 1'b1;
                end else begin
                    m_mode = 2; m_irq = 1'b1;
                end
            end
        end else if (v && m_mode == 1) begin
            m_mode = 0; m_run = 0;
        end
    endtask

    task automatic step(input logic v, input logic r, input logic c,
                        input logic y, input logic cl, input logic cc);
        @(negedge clk);
        valid_i = v; res_fault_i = r; comp_fault_i = c; ready_fault_i = y;
        clear_i = cl; cnt_clr_i = cc;
        @(posedge clk);
        model_step(v, r, c, y, cl, cc);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_i = 0; res_fault_i = 0; comp_fault_i = 0; ready_fault_i = 0;
        clear_i = 0; cnt_clr_i = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single transient fault then a clean result.
        step(1, 1, 0, 0, 0, 0);
        chk("single_retry", 32'(retry_a), 32'd1);
        chk("single_state", 32'(st_a), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("single_back_idle", 32'(st_a), 32'd0);
        chk("single_cnt", 32'(cnt_a), 32'd1);
        chk("single_src", 32'(src_a), 32'd1);

        // Fault flags without valid are ignored.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, 0);
        chk("novalid_state", 32'(st_a), 32'd0);

        // Four consecutive faults escalate to permanent.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0);
        chk("perm_level", 32'(perm_a), 32'd1);
        chk("perm_irq", 32'(irq_a), 32'd1);
        chk("perm_cnt", 32'(cnt_a), 32'd4);
        step(1, 0, 0, 1, 0, 0);
        chk("perm_irq_once", 32'(irq_a), 32'd0);

        // Clear in PERM wins over a same-cycle fault.
        step(1, 0, 1, 0, 1, 0);
        chk("clear_state", 32'(st_a), 32'd0);
        chk("clear_src", 32'(src_a), 32'd0);
        chk("clear_cnt", 32'(cnt_a), 32'd5);

        // Narrow counter saturates, then cnt_clr_i empties it.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1, 0);
        end
        chk("narrow_sat", 32'(cnt_b), 32'd3);
        step(1, 1, 0, 0, 0, 1);
        chk("narrow_clr", 32'(cnt_b), 32'd0);

        // Reset mid-RETRY drops the pending replay.
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Random traffic, biased towards bursts of faults.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            if (i % 173 == 172) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
